input_word_aligner: RTL and testbench
=====================================

Name: input_word_aligner

Overview:
- Sits directly downstream of the SCLK-domain input register cell. Consumes its registered serial bit (Q) and that cell's SP enable.
- Assembles WIDTH-bit words MSB-first and hunts for a comma/sync pattern.
- Locks word alignment after LOCK_CNT consecutive aligned sync words, then emits aligned parallel words.
- Drops lock after LOSS_CNT off-boundary sync detections.

Parameters:
- WIDTH, 10, word width in bits (4..16).
- SYNC, 10'b0011111010, alignment pattern (must be nonzero).
- LOCK_CNT, 3, consecutive boundary-aligned SYNC words needed to lock (2..15).
- LOSS_CNT, 4, cumulative off-boundary SYNC detections, without an intervening aligned SYNC, that drop lock (1..15).

Ports:
- SCLK  input  1  system clock, rising edge.
- RSTN  input  1  reset; asynchronous, active-low.
- DIN  input  1  serial bit from the upstream input register.
- DIN_EN  input  1  bit-valid; same signal as the upstream SP.
- ALIGN_EN  input  1  enables alignment; low forces HUNT.
- DOUT  output  WIDTH  aligned word.
- DOUT_VALID  output  1  one-cycle strobe qualifying DOUT.
- LOCKED  output  1  high in LOCKED state.
- STATE  output  2  00=HUNT, 01=CHECK, 10=LOCKED.
- SYNC_ERR  output  1  one-cycle pulse per off-boundary SYNC detection while LOCKED.

Behaviour:
- Reset (RSTN low, asynchronous):
  - Shift register, bit counter, good counter, error counter, DOUT, DOUT_VALID, SYNC_ERR all 0.
  - STATE=HUNT, LOCKED=0.
- Shifting:
  - sr_next = {sr[WIDTH-2:0], DIN}. sr updates only on cycles with DIN_EN=1.
  - With DIN_EN=0, all counters and state hold, and DOUT_VALID and SYNC_ERR are 0.
- Bit counter cnt:
  - Range 0..WIDTH-1. Increments on each enabled bit outside HUNT.
  - Wraps WIDTH-1 -> 0. A word completes on an enabled bit with cnt==WIDTH-1.
- HUNT:
  - On an enabled bit with sr_next==SYNC: go to CHECK, cnt=0, good=1.
  - Otherwise stay in HUNT.
- CHECK, at word completion (word = sr_next):
  - If word==SYNC: good+1. If that equals LOCK_CNT, go to LOCKED and clear the error counter.
  - If word!=SYNC: go to HUNT, good=0.
- LOCKED:
  - Every word completion registers DOUT=sr_next and DOUT_VALID=1 for exactly one cycle. SYNC words are delivered too.
  - Latency: DOUT_VALID is high the cycle after the SCLK edge sampling the word's last bit.
  - Word completion with word==SYNC: error counter cleared.
  - Enabled bit with cnt!=WIDTH-1 and sr_next==SYNC: SYNC_ERR pulse, error counter +1.
  - If the incremented error count equals LOSS_CNT: go to HUNT (LOCKED=0 next cycle). No re-detection in the same cycle.
- LOCKED output: LOCKED is registered and equals (STATE==LOCKED).
- ALIGN_EN low, from any state: next edge goes to HUNT and clears good, err and cnt. DOUT holds its last value and DOUT_VALID=0. The shift register keeps shifting on DIN_EN.
- Simultaneous events: ALIGN_EN low takes priority over any detection. Loss-of-lock takes priority over a word output in the same cycle; the word is still output because it completed on the boundary.
- Mid-operation reset: immediate return to the reset values above, with no partial word output.

Test Plan:
- Reset: hold RSTN=0 with random DIN/DIN_EN -> DOUT=0, DOUT_VALID=0, LOCKED=0, STATE=00, SYNC_ERR=0.
- Lock (WIDTH=10, DIN_EN=1, ALIGN_EN=1): bits 101, then 3×0x0FA, then 0x155 MSB-first.
  - STATE goes 01 after the 1st SYNC and 10 after the 3rd SYNC.
  - Exactly one DOUT_VALID strobe with DOUT=0x155, one cycle after its 10th bit.
- Failed check: 0x0FA then 0x000 -> STATE returns to 00 after the second word, LOCKED never rises, no DOUT_VALID.
- Stalls: repeat the lock test with DIN_EN high 1 cycle in 3 -> identical STATE/DOUT sequence, no strobes on stalled cycles.
- Slip: once locked, insert one extra bit, then stream 0x0FA repeatedly.
  - 4 SYNC_ERR pulses, then LOCKED=0.
  - Relock at the new phase after 3 further SYNC words.
- Mid-operation: while locked, drop ALIGN_EN for 1 cycle -> LOCKED=0 next edge, STATE=00. Separately, pulse RSTN low mid-word -> outputs zero without waiting for SCLK.

Source files
------------

// File: rtl/input_word_aligner.sv
// Serial-to-parallel word aligner: hunts for a SYNC comma in the SCLK-domain bit stream,
// locks word boundaries after repeated aligned SYNCs and emits aligned parallel words.
module input_word_aligner #(
  parameter int unsigned       WIDTH    = 10,
  parameter logic [WIDTH-1:0]  SYNC     = 10'b0011111010,
  parameter int unsigned       LOCK_CNT = 3,
  parameter int unsigned       LOSS_CNT = 4
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic             DIN,
  input  logic             DIN_EN,
  input  logic             ALIGN_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic             LOCKED,
  output logic [1:0]       STATE,
  output logic             SYNC_ERR
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned QW    = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]      good_q, good_d;
  logic [QW-1:0]      err_q, err_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               sync_err_q, sync_err_d;
  logic               locked_q, locked_d;

  logic [WIDTH-1:0]   sr_next;
  logic               word_done;
  logic               is_sync;
  logic [QW-1:0]      good_inc;
  logic [QW-1:0]      err_inc;

  // State and output registers
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_HUNT;
      sr_q         <= '0;
      cnt_q        <= '0;
      good_q       <= '0;
      err_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= locked_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    good_d       = good_q;
    err_d        = err_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    sr_next   = {sr_q[WIDTH-2:0], DIN};
    word_done = (cnt_q == CNT_W'(WIDTH - 1));
    is_sync   = (sr_next == SYNC);
    good_inc  = good_q + QW'(1);
    err_inc   = err_q + QW'(1);

    if (DIN_EN) begin
      sr_d = sr_next;
    end

    if (!ALIGN_EN) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
      good_d  = '0;
      err_d   = '0;
    end else if (DIN_EN) begin
      if (state_q != ST_HUNT) begin
        cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
            good_d  = QW'(1);
          end
        end
        ST_CHECK: begin
          if (word_done) begin
            if (is_sync) begin
              good_d = good_inc;
              if (good_inc == QW'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                err_d   = '0;
              end
            end else begin
              state_d = ST_HUNT;
              good_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (word_done) begin
            dout_d       = sr_next;
            dout_valid_d = 1'b1;
            if (is_sync) begin
              err_d = '0;
            end
          end else if (is_sync) begin
            // Off-boundary comma: count it, and give up the alignment once too many pile up
            sync_err_d = 1'b1;
            err_d      = err_inc;
            if (err_inc == QW'(LOSS_CNT)) begin
              state_d = ST_HUNT;
              good_d  = '0;
              err_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
          good_d  = '0;
          err_d   = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign LOCKED     = locked_q;
  assign STATE      = state_q;
  assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_input_word_aligner.sv
// Self-checking bench for input_word_aligner: table-driven word sequences with a strobe
// scoreboard, plus hand-written reset, ALIGN_EN drop and mid-word reset sequences.
module tb_input_word_aligner;

  localparam logic [9:0] SYNC_W = 10'h0FA;
  localparam logic [9:0] PAY_W  = 10'h155;

  logic       SCLK = 1'b0;
  logic       RSTN;
  logic       DIN;
  logic       DIN_EN;
  logic       ALIGN_EN;
  logic [9:0] DOUT;
  logic       DOUT_VALID;
  logic       LOCKED;
  logic [1:0] STATE;
  logic       SYNC_ERR;

  input_word_aligner dut (
    .SCLK       (SCLK),
    .RSTN       (RSTN),
    .DIN        (DIN),
    .DIN_EN     (DIN_EN),
    .ALIGN_EN   (ALIGN_EN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .LOCKED     (LOCKED),
    .STATE      (STATE),
    .SYNC_ERR   (SYNC_ERR)
  );

  always #5 SCLK = ~SCLK;

  int unsigned cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  // One record per sent word: bits, state after its last bit, and any strobe expected inside it
  typedef struct {
    logic [9:0] word;
    int         nbits;
    logic [1:0] st;
    logic       lk;
    int         out_idx;
    logic [9:0] out_word;
    int         errs;
  } vec_t;

  typedef struct {
    logic [9:0]  word;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   err_seen = 0;

  function automatic vec_t mk(logic [9:0] w, int nb, logic [1:0] st, logic lk,
                              int oi, logic [9:0] ow, int er);
    vec_t v;
    v.word = w; v.nbits = nb; v.st = st; v.lk = lk;
    v.out_idx = oi; v.out_word = ow; v.errs = er;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then observe the registered outputs just after the edge
  task automatic tick(logic b, logic en, logic al);
    exp_t e;
    @(negedge SCLK);
    DIN = b; DIN_EN = en; ALIGN_EN = al;
    @(posedge SCLK);
    #1;
    if (SYNC_ERR) err_seen++;
    if (DOUT_VALID) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got DOUT_VALID=1 DOUT=0x%0h at cycle %0d, required no strobe",
                 DOUT, cyc);
      end else begin
        e = sb.pop_front();
        check("dout_word", 32'(DOUT), 32'(e.word));
        check("dout_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic send_word(vec_t v, bit stall, int idx);
    exp_t e;
    err_seen = 0;
    for (int i = 0; i < v.nbits; i++) begin
      if (stall) repeat (2) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      if (i == v.out_idx) begin
        e.word = v.out_word;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      tick(v.word[v.nbits-1-i], 1'b1, 1'b1);
    end
    check($sformatf("state[%0d]", idx), 32'(STATE), 32'(v.st));
    check($sformatf("locked[%0d]", idx), 32'(LOCKED), 32'(v.lk));
    check($sformatf("sync_err_cnt[%0d]", idx), 32'(err_seen), 32'(v.errs));
  endtask

  task automatic run_tbl(bit stall);
    foreach (tbl[i]) send_word(tbl[i], stall, i);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic fill_lock();
    tbl.delete();
    tbl.push_back(mk(10'b101, 3, 2'b00, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b01, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b01, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b10, 1'b1, -1, 10'h0, 0));
    tbl.push_back(mk(PAY_W, 10, 2'b10, 1'b1, 9, PAY_W, 0));
  endtask

  // Hold reset with random inputs; outputs must be zero throughout. Leaves phase at edge+1.
  task automatic do_reset();
    RSTN = 1'b0;
    #1;
    check("reset_async", 32'({DOUT, DOUT_VALID, LOCKED, STATE, SYNC_ERR}), 32'd0);
    repeat (4) begin
      @(negedge SCLK);
      DIN = 1'($urandom_range(0, 1));
      DIN_EN = 1'($urandom_range(0, 1));
      @(posedge SCLK);
      #1;
      check("reset_hold", 32'({DOUT, DOUT_VALID, LOCKED, STATE, SYNC_ERR}), 32'd0);
    end
    @(negedge SCLK);
    RSTN = 1'b1;
    DIN_EN = 1'b0;
    @(posedge SCLK);
    #1;
    sb.delete();
  endtask

  initial begin
    RSTN = 1'b0; DIN = 1'b0; DIN_EN = 1'b0; ALIGN_EN = 1'b1;
    @(posedge SCLK);
    #1;
    do_reset();

    // Basic lock and first payload word
    fill_lock();
    run_tbl(1'b0);

    // Dropping ALIGN_EN for one cycle forces HUNT, DOUT holds
    tick(1'b1, 1'b1, 1'b0);
    check("align_drop_state", 32'(STATE), 32'd0);
    check("align_drop_locked", 32'(LOCKED), 32'd0);
    check("align_drop_dout", 32'(DOUT), 32'(PAY_W));
    check("align_drop_valid", 32'(DOUT_VALID), 32'd0);

    // Failed check: SYNC followed by a non-SYNC word
    do_reset();
    tbl.delete();
    tbl.push_back(mk(SYNC_W, 10, 2'b01, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(10'h000, 10, 2'b00, 1'b0, -1, 10'h0, 0));
    run_tbl(1'b0);

    // Lock sequence with DIN_EN high one cycle in three
    do_reset();
    fill_lock();
    run_tbl(1'b1);

    // Slip by one bit after locking, then relock at the new phase
    do_reset();
    fill_lock();
    void'(tbl.pop_back());
    tbl.push_back(mk(10'b1, 1, 2'b10, 1'b1, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b10, 1'b1, 8, 10'h27D, 1));
    tbl.push_back(mk(SYNC_W, 10, 2'b10, 1'b1, 8, 10'h07D, 1));
    tbl.push_back(mk(SYNC_W, 10, 2'b10, 1'b1, 8, 10'h07D, 1));
    tbl.push_back(mk(SYNC_W, 10, 2'b00, 1'b0, 8, 10'h07D, 1));
    tbl.push_back(mk(SYNC_W, 10, 2'b01, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b01, 1'b0, -1, 10'h0, 0));
    tbl.push_back(mk(SYNC_W, 10, 2'b10, 1'b1, -1, 10'h0, 0));
    tbl.push_back(mk(PAY_W, 10, 2'b10, 1'b1, 9, PAY_W, 0));
    run_tbl(1'b0);

    // Reset pulse mid-word while locked takes effect without a clock edge
    for (int i = 0; i < 5; i++) tick(PAY_W[9-i], 1'b1, 1'b1);
    @(negedge SCLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("midword_reset", 32'({DOUT, DOUT_VALID, LOCKED, STATE, SYNC_ERR}), 32'd0);
    @(posedge SCLK);
    #1;
    check("midword_reset_hold", 32'({DOUT, DOUT_VALID, LOCKED, STATE, SYNC_ERR}), 32'd0);
    @(negedge SCLK);
    RSTN = 1'b1;
    DIN_EN = 1'b0;
    @(posedge SCLK);
    #1;
    sb.delete();

    // Clean relock after the mid-word reset
    fill_lock();
    run_tbl(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
